// File: rtl/axis_ddr3_writer_pkg.sv
// Shared DDR3 user-app definitions for the AXI-Stream to DDR3 writer.
// Command encodings, word/mask widths and the default address step.
package axis_ddr3_writer_pkg;

  localparam int unsigned DATA_W        = 128;
  localparam int unsigned MASK_W        = 16;
  localparam int unsigned LANE_CNT_W    = 4;
  localparam int unsigned DEF_ADDR_STEP = 8;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } wr_word_t;

endpackage

// File: rtl/axis_word_packer.sv
// Packs accepted bytes into 16 lanes of a 128-bit word, clearing each lane's mask bit.
// Flags completion on the 16th byte or on a tlast byte; partial words keep unfilled lanes zero and masked.
module axis_word_packer
  import axis_ddr3_writer_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       accept,
  input  logic       last,
  input  logic       clear,
  input  logic [7:0] byte_data,
  output wr_word_t   word,
  output logic       done_c
);

  logic [LANE_CNT_W-1:0] cnt_q;
  wr_word_t              word_q;

  assign done_c = accept && (last || (cnt_q == LANE_CNT_W'(MASK_W - 1)));
  assign word   = word_q;

  // Lane write and word clear after the controller takes the data beat
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q       <= '0;
      word_q.data <= '0;
      word_q.mask <= '1;
    end else if (clear) begin
      cnt_q       <= '0;
      word_q.data <= '0;
      word_q.mask <= '1;
    end else if (accept) begin
      word_q.data[{cnt_q, 3'b000} +: 8] <= byte_data;
      word_q.mask[cnt_q]                <= 1'b0;
      cnt_q                             <= cnt_q + LANE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/axis_ddr3_writer.sv
// AXI-Stream byte sink that writes packed 128-bit words to the DDR3 user app interface.
// Define AXIS_DDR3_WRITER_WRAP_EN to wrap the address ring at END_ADDR instead of stopping in FULL.
module axis_ddr3_writer
  import axis_ddr3_writer_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 27,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = ADDR_WIDTH'(27'h7FFFFF8),
  parameter int unsigned           ADDR_STEP  = DEF_ADDR_STEP
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  calib_done_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  input  logic                  s_axis_tlast_i,
  input  logic [7:0]            s_axis_tdata_i,
  output logic                  cmd_en_o,
  output logic [2:0]            cmd_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic                  cmd_ready_i,
  output logic                  wr_data_en_o,
  output logic                  wr_data_end_o,
  output logic [DATA_W-1:0]     wr_data_o,
  output logic [MASK_W-1:0]     wr_data_mask_o,
  input  logic                  wr_data_rdy_i,
  output logic                  busy_o,
  output logic                  full_o
);

  localparam logic [2:0] WAIT_CAL = 3'd0;
  localparam logic [2:0] FILL     = 3'd1;
  localparam logic [2:0] CMD      = 3'd2;
  localparam logic [2:0] DATA     = 3'd3;
  localparam logic [2:0] FULL     = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  tready_q, tready_d;
  logic                  cmd_en_q, cmd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic                  busy_q, busy_d;
  logic                  full_q, full_d;
  logic                  accept_c;
  logic                  word_done_c;
  logic                  clear_c;
  wr_word_t              word;

  assign accept_c = s_axis_tvalid_i && tready_q;

  axis_word_packer u_packer (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .accept    (accept_c),
    .last      (s_axis_tlast_i),
    .clear     (clear_c),
    .byte_data (s_axis_tdata_i),
    .word      (word),
    .done_c    (word_done_c)
  );

  // Next state, address and registered output values
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    clear_c  = 1'b0;
    case (state_q)
      WAIT_CAL: if (calib_done_i) state_d = FILL;
      FILL: begin
        // A completing byte always commits the word, even if calibration just dropped
        if (word_done_c)        state_d = CMD;
        else if (!calib_done_i) state_d = WAIT_CAL;
      end
      CMD: if (cmd_ready_i) state_d = DATA;
      DATA: begin
        if (wr_data_rdy_i) begin
          clear_c = 1'b1;
          if (addr_q == END_ADDR) begin
`ifdef AXIS_DDR3_WRITER_WRAP_EN
            addr_d  = BASE_ADDR;
            state_d = FILL;
`else
            state_d = FULL;
`endif
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(ADDR_STEP);
            state_d = FILL;
          end
        end
      end
      FULL:    state_d = FULL;
      default: state_d = WAIT_CAL;
    endcase
    tready_d = (state_d == FILL);
    cmd_en_d = (state_d == CMD);
    wr_en_d  = (state_d == DATA);
    busy_d   = cmd_en_d || wr_en_d;
    full_d   = (state_d == FULL);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= WAIT_CAL;
      addr_q   <= BASE_ADDR;
      tready_q <= 1'b0;
      cmd_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tready_q <= tready_d;
      cmd_en_q <= cmd_en_d;
      wr_en_q  <= wr_en_d;
      busy_q   <= busy_d;
      full_q   <= full_d;
    end
  end

  assign s_axis_tready_o = tready_q;
  assign cmd_en_o        = cmd_en_q;
  assign cmd_o           = CMD_WRITE;
  assign addr_o          = addr_q;
  assign wr_data_en_o    = wr_en_q;
  assign wr_data_end_o   = wr_en_q;
  assign wr_data_o       = word.data;
  assign wr_data_mask_o  = word.mask;
  assign busy_o          = busy_q;
  assign full_o          = full_q;

endmodule

// File: tb/tb_axis_ddr3_writer.sv
// Scoreboard bench for axis_ddr3_writer: directed byte streams, expected writes queued, monitor checks.
`timescale 1ns/1ps
module tb_axis_ddr3_writer;

  localparam int unsigned AW = 27;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [127:0]  data;
    logic [15:0]   mask;
  } exp_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          calib_done_i = 1'b0;
  logic          s_axis_tvalid_i = 1'b0;
  logic          s_axis_tready_o;
  logic          s_axis_tlast_i = 1'b0;
  logic [7:0]    s_axis_tdata_i = 8'h00;
  logic          cmd_en_o;
  logic [2:0]    cmd_o;
  logic [AW-1:0] addr_o;
  logic          cmd_ready_i = 1'b0;
  logic          wr_data_en_o;
  logic          wr_data_end_o;
  logic [127:0]  wr_data_o;
  logic [15:0]   wr_data_mask_o;
  logic          wr_data_rdy_i = 1'b0;
  logic          busy_o;
  logic          full_o;

  int tests = 0;
  int fails = 0;
  int cmd_stall = 0;
  int dat_stall = 0;
  exp_t exp_q[$];

  axis_ddr3_writer #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (27'd0),
    .END_ADDR   (27'd32),
    .ADDR_STEP  (8)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .calib_done_i    (calib_done_i),
    .s_axis_tvalid_i (s_axis_tvalid_i),
    .s_axis_tready_o (s_axis_tready_o),
    .s_axis_tlast_i  (s_axis_tlast_i),
    .s_axis_tdata_i  (s_axis_tdata_i),
    .cmd_en_o        (cmd_en_o),
    .cmd_o           (cmd_o),
    .addr_o          (addr_o),
    .cmd_ready_i     (cmd_ready_i),
    .wr_data_en_o    (wr_data_en_o),
    .wr_data_end_o   (wr_data_end_o),
    .wr_data_o       (wr_data_o),
    .wr_data_mask_o  (wr_data_mask_o),
    .wr_data_rdy_i   (wr_data_rdy_i),
    .busy_o          (busy_o),
    .full_o          (full_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tready"}, 128'(s_axis_tready_o), 128'd0);
    chk({tag, "_cmd_en"}, 128'(cmd_en_o), 128'd0);
    chk({tag, "_cmd"}, 128'(cmd_o), 128'd0);
    chk({tag, "_addr"}, 128'(addr_o), 128'd0);
    chk({tag, "_wr_en"}, 128'(wr_data_en_o), 128'd0);
    chk({tag, "_wr_end"}, 128'(wr_data_end_o), 128'd0);
    chk({tag, "_data"}, wr_data_o, 128'd0);
    chk({tag, "_mask"}, 128'(wr_data_mask_o), 128'hFFFF);
    chk({tag, "_busy"}, 128'(busy_o), 128'd0);
    chk({tag, "_full"}, 128'(full_o), 128'd0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    s_axis_tvalid_i = 1'b1;
    s_axis_tdata_i  = d;
    s_axis_tlast_i  = last;
    forever begin
      @(negedge aclk);
      if (s_axis_tready_o) break;
      n++;
      if (n > 2000) begin
        tests++; fails++;
        $display("FAIL send_byte_timeout: byte %h never accepted", d);
        break;
      end
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid_i = 1'b0;
    s_axis_tlast_i  = 1'b0;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [127:0] d, input logic [15:0] m);
    exp_t e;
    e.addr = a; e.data = d; e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    @(posedge aclk);
    #1;
    chk({name, "_pending_writes"}, 128'(exp_q.size()), 128'd0);
  endtask

  // Controller model: hold ready low for a programmable number of cycles per strobe
  initial begin
    int cmd_wait = 0;
    int dat_wait = 0;
    forever begin
      @(posedge aclk);
      #1;
      if (cmd_en_o) begin
        if (cmd_wait < cmd_stall) begin cmd_ready_i = 1'b0; cmd_wait++; end
        else cmd_ready_i = 1'b1;
      end else begin
        cmd_ready_i = 1'b0; cmd_wait = 0;
      end
      if (wr_data_en_o) begin
        if (dat_wait < dat_stall) begin wr_data_rdy_i = 1'b0; dat_wait++; end
        else wr_data_rdy_i = 1'b1;
      end else begin
        wr_data_rdy_i = 1'b0; dat_wait = 0;
      end
    end
  end

  // Monitor: handshake-level checks and scoreboard pops
  initial begin
    logic          cmd_held = 1'b0;
    logic          dat_held = 1'b0;
    logic          cmd_pending = 1'b0;
    logic [AW-1:0] held_addr = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [127:0]  held_data = '0;
    logic [15:0]   held_mask = '0;
    exp_t          e;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        cmd_held = 1'b0; dat_held = 1'b0; cmd_pending = 1'b0;
      end else begin
        if (busy_o) chk("tready_while_busy", 128'(s_axis_tready_o), 128'd0);
        if (cmd_en_o) begin
          if (cmd_held) chk("cmd_addr_stable", 128'(addr_o), 128'(held_addr));
          else begin held_addr = addr_o; cmd_held = 1'b1; end
          if (cmd_ready_i) begin
            chk("cmd_is_write", 128'(cmd_o), 128'd0);
            chk("cmd_before_cmd", 128'(cmd_pending), 128'd0);
            cmd_addr    = addr_o;
            cmd_pending = 1'b1;
          end
        end else cmd_held = 1'b0;
        if (wr_data_en_o) begin
          if (dat_held) begin
            chk("data_stable", wr_data_o, held_data);
            chk("mask_stable", 128'(wr_data_mask_o), 128'(held_mask));
          end else begin
            held_data = wr_data_o; held_mask = wr_data_mask_o; dat_held = 1'b1;
          end
          if (wr_data_rdy_i) begin
            chk("wr_data_end", 128'(wr_data_end_o), 128'd1);
            chk("cmd_before_data", 128'(cmd_pending), 128'd1);
            cmd_pending = 1'b0;
            if (exp_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_write: addr %h data %h", cmd_addr, wr_data_o);
            end else begin
              e = exp_q.pop_front();
              chk("wr_addr", 128'(cmd_addr), 128'(e.addr));
              chk("wr_data", wr_data_o, e.data);
              chk("wr_mask", 128'(wr_data_mask_o), 128'(e.mask));
            end
          end
        end else dat_held = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] b2b_data [4];
    int n;
    b2b_data[0] = 128'h0F0E0D0C0B0A09080706050403020100;
    b2b_data[1] = 128'h1F1E1D1C1B1A19181716151413121110;
    b2b_data[2] = 128'h2F2E2D2C2B2A29282726252423222120;
    b2b_data[3] = 128'h3F3E3D3C3B3A39383736353433323130;

    repeat (3) @(negedge aclk);
    check_reset_vals("reset");
    aresetn = 1'b1;

    // Calibration gating
    s_axis_tvalid_i = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      chk("tready_pre_calib", 128'(s_axis_tready_o), 128'd0);
    end
    calib_done_i = 1'b1;
    push_exp(27'd0, 128'h0F0E0D0C0B0A09080706050403020100, 16'h0000);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    drain("calib_gate");

    // Calibration drop mid-fill keeps the partial word
    push_exp(27'd8, 128'h6F6E6D6C6B6A69686766656463626160, 16'h0000);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h60 + i), 1'b0);
    calib_done_i = 1'b0;
    @(posedge aclk);
    repeat (4) begin
      @(negedge aclk);
      chk("tready_calib_drop", 128'(s_axis_tready_o), 128'd0);
    end
    calib_done_i = 1'b1;
    for (int i = 5; i < 16; i++) send_byte(8'(8'h60 + i), 1'b0);
    drain("calib_drop");

    // Partial packet flushed by tlast
    push_exp(27'd16, 128'h000000000000000000000000_00CCBBAA, 16'hFFF8);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    drain("partial");

    // Backpressure on both command and data
    cmd_stall = 5;
    dat_stall = 3;
    push_exp(27'd24, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 16'h0000);
    for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i), 1'b0);
    drain("backpressure");
    cmd_stall = 0;
    dat_stall = 0;

    // Reset while the data beat is stalled
    dat_stall = 1000000;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h70 + i), 1'b0);
    n = 0;
    while (!wr_data_en_o && n < 100) begin @(negedge aclk); n++; end
    chk("mid_data_reached", 128'(wr_data_en_o), 128'd1);
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 check_reset_vals("mid_data");
    @(negedge aclk);
    aresetn   = 1'b1;
    dat_stall = 0;
    push_exp(27'd0, 128'h5F5E5D5C5B5A59585756555453525150, 16'h0000);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h50 + i), 1'b0);
    drain("after_reset");

    // Back-to-back 64 bytes from a fresh reset
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int w = 0; w < 4; w++) push_exp(AW'(w * 8), b2b_data[w], 16'h0000);
    for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
    drain("back_to_back");

    // Last legal word, then wrap or stop
    push_exp(27'd32, 128'h8F8E8D8C8B8A89888786858483828180, 16'h0000);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b0);
    drain("end_addr");
    repeat (3) @(negedge aclk);
`ifdef AXIS_DDR3_WRITER_WRAP_EN
    chk("full_wrap", 128'(full_o), 128'd0);
    push_exp(27'd0, 128'h9F9E9D9C9B9A99989796959493929190, 16'h0000);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h90 + i), 1'b0);
    drain("wrap");
    chk("full_after_wrap", 128'(full_o), 128'd0);
`else
    chk("full_set", 128'(full_o), 128'd1);
    s_axis_tvalid_i = 1'b1;
    s_axis_tdata_i  = 8'h99;
    repeat (8) begin
      @(negedge aclk);
      chk("tready_full", 128'(s_axis_tready_o), 128'd0);
      chk("cmd_en_full", 128'(cmd_en_o), 128'd0);
    end
    s_axis_tvalid_i = 1'b0;
    chk("full_held", 128'(full_o), 128'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
